// File: rtl/alu_arb_if.sv
// Request/response/ALU bundle for alu_arbiter: two requesters, one response channel,
// and the combinational ALU hookup. slave = arbiter side, master = requesters + ALU.
interface alu_arb_if #(parameter int W = 64);
  logic         req0_valid, req0_ready, req0_setcc;
  logic [W-1:0] req0_a, req0_b;
  logic [1:0]   req0_fun;
  logic         req1_valid, req1_ready, req1_setcc;
  logic [W-1:0] req1_a, req1_b;
  logic [1:0]   req1_fun;
  logic         rsp_valid, rsp_id, rsp_ready;
  logic [W-1:0] rsp_valE;
  logic [2:0]   rsp_cc;
  logic [W-1:0] ALUA, ALUB, valE;
  logic [1:0]   ALUfun;
  logic [2:0]   CC, cc_reg;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun, req0_setcc,
    input  req1_valid, req1_a, req1_b, req1_fun, req1_setcc,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_valE, rsp_cc, input rsp_ready,
    output ALUA, ALUB, ALUfun, input valE, CC,
    output cc_reg
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_fun, req0_setcc,
    output req1_valid, req1_a, req1_b, req1_fun, req1_setcc,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_valE, rsp_cc, output rsp_ready,
    input  ALUA, ALUB, ALUfun, output valE, CC,
    input  cc_reg
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared Y86-64 ALU; owns cc_reg.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties).
module alu_arbiter #(
  parameter int W = 64
) (
  input  logic       clk,
  input  logic       rst,
  alu_arb_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]   r_state;
  logic [W-1:0] r_a, r_b, r_valE;
  logic [1:0]   r_fun;
  logic         r_setcc, r_id;
  logic [2:0]   r_cc, r_cc_reg;
  logic         w_idle, w_gnt0, w_gnt1, w_hs;

  assign w_idle = (r_state == S_IDLE);

`ifdef ALU_ARB_FIXED_PRI_EN
  assign w_gnt1 = bus.req1_valid && !bus.req0_valid;
`else
  logic r_last_grant;
  // On a tie requester 1 wins only if requester 0 was granted last.
  assign w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_last_grant <= 1'b1;
    else if (w_hs) r_last_grant <= w_gnt1;
  end
`endif

  assign w_gnt0 = bus.req0_valid && !w_gnt1;
  assign w_hs   = w_idle && (w_gnt0 || w_gnt1);

  assign bus.req0_ready = w_idle && w_gnt0;
  assign bus.req1_ready = w_idle && w_gnt1;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_valE   = r_valE;
  assign bus.rsp_cc     = r_cc;
  assign bus.ALUA       = r_a;
  assign bus.ALUB       = r_b;
  assign bus.ALUfun     = r_fun;
  assign bus.cc_reg     = r_cc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_fun    <= 2'b00;
      r_setcc  <= 1'b0;
      r_id     <= 1'b0;
      r_valE   <= '0;
      r_cc     <= 3'b000;
      r_cc_reg <= 3'b100;
    end else begin
      case (r_state)
        S_IDLE: if (w_hs) begin
          r_a     <= w_gnt1 ? bus.req1_a     : bus.req0_a;
          r_b     <= w_gnt1 ? bus.req1_b     : bus.req0_b;
          r_fun   <= w_gnt1 ? bus.req1_fun   : bus.req0_fun;
          r_setcc <= w_gnt1 ? bus.req1_setcc : bus.req0_setcc;
          r_id    <= w_gnt1;
          r_state <= S_EXEC;
        end
        // The ALU is only sampled here, so its flags never leak into state elsewhere.
        S_EXEC: begin
          r_valE  <= bus.valE;
          r_cc    <= bus.CC;
          if (r_setcc) r_cc_reg <= bus.CC;
          r_state <= S_RESP;
        end
        S_RESP: if (bus.rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU model driving valE/CC.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arb_if #(.W(64)) bus ();
  alu_arbiter #(.W(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic        id;
    logic [63:0] valE;
    logic [2:0]  cc;
    logic [2:0]  ccreg;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] model_cc = 3'b100;

  // Returns {ZF, SF, OF, result}.
  function automatic logic [66:0] alu_f(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic        of;
    case (f)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = a ^ b;
    endcase
    of = 1'b0;
    if (f == 2'b00) of = (a[63] == b[63]) && (r[63] != a[63]);
    if (f == 2'b01) of = (a[63] != b[63]) && (r[63] != a[63]);
    return {(r == 64'd0), r[63], of, r};
  endfunction

  always_comb {bus.CC, bus.valE} = alu_f(bus.ALUfun, bus.ALUA, bus.ALUB);

  task automatic push(input logic id, input logic [1:0] f, input logic [63:0] a, input logic [63:0] b, input logic setcc);
    logic [66:0] x;
    x = alu_f(f, a, b);
    if (setcc) model_cc = x[66:64];
    sb.push_back('{id: id, valE: x[63:0], cc: x[66:64], ccreg: model_cc});
  endtask

  task automatic set_req(input int r, input logic v, input logic [1:0] f, input logic [63:0] a, input logic [63:0] b, input logic s);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_fun = f; bus.req0_a = a; bus.req0_b = b; bus.req0_setcc = s;
    end else begin
      bus.req1_valid = v; bus.req1_fun = f; bus.req1_a = a; bus.req1_b = b; bus.req1_setcc = s;
    end
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    set_req(0, 0, 2'b00, 0, 0, 0);
    set_req(1, 0, 2'b00, 0, 0, 0);
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_valE !== 64'd0 || bus.rsp_cc !== 3'b000) begin
      n_bad++; $display("FAIL reset_rsp valid=%b id=%b valE=%0h cc=%b want 0/0/0/000", bus.rsp_valid, bus.rsp_id, bus.rsp_valE, bus.rsp_cc);
    end
    n_cmp++;
    if (bus.cc_reg !== 3'b100 || bus.ALUfun !== 2'b00 || bus.ALUA !== 64'd0 || bus.ALUB !== 64'd0) begin
      n_bad++; $display("FAIL reset_state cc_reg=%b fun=%b A=%0h B=%0h want 100/00/0/0", bus.cc_reg, bus.ALUfun, bus.ALUA, bus.ALUB);
    end
    rst = 1'b0;
    model_cc = 3'b100;
    @(negedge clk);
  endtask

  task automatic test_single_add;
    set_req(0, 1, 2'b00, 64'd45, 64'd38, 1);
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_bad++; $display("FAIL add_ready r0=%b r1=%b want 1/0", bus.req0_ready, bus.req1_ready);
    end
    push(0, 2'b00, 64'd45, 64'd38, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.ALUA !== 64'd45 || bus.ALUB !== 64'd38) begin
      n_bad++; $display("FAIL add_exec valid=%b r0=%b A=%0d B=%0d want 0/0/45/38", bus.rsp_valid, bus.req0_ready, bus.ALUA, bus.ALUB);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1) begin
      n_bad++; $display("FAIL add_latency rsp_valid=%b want 1", bus.rsp_valid);
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus.rsp_id !== e.id || bus.rsp_valE !== e.valE || bus.rsp_cc !== e.cc || bus.cc_reg !== e.ccreg) begin
      n_bad++; $display("FAIL add_rsp id=%b/%b valE=%0d/%0d cc=%b/%b ccreg=%b/%b", bus.rsp_id, e.id, bus.rsp_valE, e.valE, bus.rsp_cc, e.cc, bus.cc_reg, e.ccreg);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL add_consume rsp_valid=%b want 0", bus.rsp_valid);
    end
    bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit got;
    set_req(1, 1, 2'b10, 64'd45, 64'd38, 0);
    #1;
    n_cmp++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_ready r0=%b r1=%b want 0/1", bus.req0_ready, bus.req1_ready);
    end
    push(1, 2'b10, 64'd45, 64'd38, 0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    #1;
    wait_rsp(got);
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL bp_timeout rsp_valid=0 want 1"); end
    e = sb.pop_front();
    // A request arriving during RESP must not be accepted, then withdraws.
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_valE !== e.valE || bus.rsp_cc !== e.cc || bus.cc_reg !== e.ccreg || bus.req0_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d] valid=%b id=%b/%b valE=%0d/%0d cc=%b/%b ccreg=%b/%b r0=%b", i, bus.rsp_valid, bus.rsp_id, e.id, bus.rsp_valE, e.valE, bus.rsp_cc, e.cc, bus.cc_reg, e.ccreg, bus.req0_ready);
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_release valid=%b r0=%b want 0/0", bus.rsp_valid, bus.req0_ready);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_dropped_req rsp_valid=%b want 0", bus.rsp_valid); end
    bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic exp_ids [4];
    int   hs = 0, last = 0, cyc = 0, got = 0;
    bit   drop = 0;
`ifdef ALU_ARB_FIXED_PRI_EN
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    set_req(0, 1, 2'b11, 64'd45, 64'd38, 0);
    set_req(1, 1, 2'b11, 64'd45, 64'd38, 0);
    bus.rsp_ready = 1'b1;
    while (got < 4 && cyc < 40) begin
      #1;
      if (bus.rsp_valid) begin
        got++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra_rsp id=%b valE=%0d want none", bus.rsp_id, bus.rsp_valE);
        end else begin
          e = sb.pop_front();
          if (bus.rsp_id !== e.id || bus.rsp_valE !== e.valE || bus.rsp_cc !== e.cc || bus.cc_reg !== e.ccreg) begin
            n_bad++; $display("FAIL b2b_rsp id=%b/%b valE=%0d/%0d cc=%b/%b ccreg=%b/%b", bus.rsp_id, e.id, bus.rsp_valE, e.valE, bus.rsp_cc, e.cc, bus.cc_reg, e.ccreg);
          end
        end
      end
      if (hs < 4 && (bus.req0_ready || bus.req1_ready)) begin
        n_cmp++;
        if ({bus.req1_ready, bus.req0_ready} !== (exp_ids[hs] ? 2'b10 : 2'b01)) begin
          n_bad++; $display("FAIL b2b_grant[%0d] ready={r1,r0}=%b want id %0d", hs, {bus.req1_ready, bus.req0_ready}, exp_ids[hs]);
        end
        if (hs > 0) begin
          n_cmp++;
          if (cyc - last != 3) begin n_bad++; $display("FAIL b2b_spacing[%0d] gap=%0d want 3", hs, cyc - last); end
        end
        push(exp_ids[hs], 2'b11, 64'd45, 64'd38, 0);
        last = cyc;
        hs++;
        if (hs == 4) drop = 1;
      end
      @(negedge clk);
      cyc++;
      if (drop) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; drop = 0; end
    end
    n_cmp++;
    if (got != 4 || hs != 4) begin n_bad++; $display("FAIL b2b_count rsps=%0d grants=%0d want 4/4", got, hs); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_overflow_sub;
    bit got;
    logic [63:0] av [2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd5};
    logic [63:0] bv [2] = '{64'd1, 64'd9};
    logic [1:0]  fv [2] = '{2'b00, 2'b01};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_req(k, 1, fv[k], av[k], bv[k], 1);
      #1;
      n_cmp++;
      if ((k == 0 ? bus.req0_ready : bus.req1_ready) !== 1'b1) begin
        n_bad++; $display("FAIL ovf_ready[%0d] ready=0 want 1", k);
      end
      push(k[0], fv[k], av[k], bv[k], 1);
      @(negedge clk);
      set_req(k, 0, fv[k], av[k], bv[k], 1);
      #1;
      wait_rsp(got);
      e = sb.pop_front();
      n_cmp++;
      if (!got || bus.rsp_id !== e.id || bus.rsp_valE !== e.valE || bus.rsp_cc !== e.cc || bus.cc_reg !== e.ccreg) begin
        n_bad++; $display("FAIL ovf_rsp[%0d] got=%b id=%b/%b valE=%0h/%0h cc=%b/%b ccreg=%b/%b", k, got, bus.rsp_id, e.id, bus.rsp_valE, e.valE, bus.rsp_cc, e.cc, bus.cc_reg, e.ccreg);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_zero_reset_exec;
    bit got;
    @(negedge clk);
    set_req(0, 1, 2'b00, 64'd0, 64'd0, 1);
    #1;
    push(0, 2'b00, 64'd0, 64'd0, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    wait_rsp(got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || bus.rsp_cc !== e.cc || bus.cc_reg !== e.ccreg || bus.rsp_valE !== e.valE) begin
      n_bad++; $display("FAIL zero_rsp got=%b cc=%b/%b ccreg=%b/%b valE=%0h/%0h", got, bus.rsp_cc, e.cc, bus.cc_reg, e.ccreg, bus.rsp_valE, e.valE);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    // New op sets SF if it completes; reset lands during its EXEC cycle.
    set_req(0, 1, 2'b01, 64'd5, 64'd9, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_cc = 3'b100;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.cc_reg !== 3'b100) begin
        n_bad++; $display("FAIL exec_reset[%0d] rsp_valid=%b cc_reg=%b want 0/100", i, bus.rsp_valid, bus.cc_reg);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset_resp;
    bit got;
    set_req(0, 1, 2'b10, 64'd12, 64'd10, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    wait_rsp(got);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (!got || bus.rsp_valid !== 1'b0 || bus.cc_reg !== 3'b100) begin
      n_bad++; $display("FAIL resp_async_reset got=%b rsp_valid=%b cc_reg=%b want 1/0/100", got, bus.rsp_valid, bus.cc_reg);
    end
    #1 rst = 1'b0;
    model_cc = 3'b100;
    @(negedge clk);
    set_req(0, 1, 2'b00, 64'd1, 64'd2, 0);
    set_req(1, 1, 2'b00, 64'd3, 64'd4, 0);
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_grant r0=%b r1=%b want 1/0", bus.req0_ready, bus.req1_ready);
    end
    push(0, 2'b00, 64'd1, 64'd2, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    wait_rsp(got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || bus.rsp_id !== e.id || bus.rsp_valE !== e.valE || bus.rsp_cc !== e.cc || bus.cc_reg !== e.ccreg) begin
      n_bad++; $display("FAIL post_reset_rsp got=%b id=%b/%b valE=%0d/%0d cc=%b/%b ccreg=%b/%b", got, bus.rsp_id, e.id, bus.rsp_valE, e.valE, bus.rsp_cc, e.cc, bus.cc_reg, e.ccreg);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_backpressure();
    test_back_to_back();
    test_overflow_sub();
    test_zero_reset_exec();
    test_async_reset_resp();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover entries=%0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
